lsu_data_if: RTL and testbench

- Load/store unit sitting between EX and the write-back stage.
- Accepts one memory operation at a time from EX and runs the data-memory req/gnt/rvalid protocol. Misaligned accesses are split into two word-aligned bus transactions.
- Load data is extracted, merged and sign/zero-extended, then returned to write-back as a single-cycle register-file write strobe with address and data.

---
 rtl/lsu_data_if.sv | 184 ++++++++++++++++++
 tb/tb_lsu_data_if.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_if.sv
// Load/store unit: runs the data-memory req/gnt/rvalid handshake for one EX operation at a time,
// splitting misaligned accesses into two word transactions and returning aligned, extended load data.
module lsu_data_if #(
  parameter bit ERR_ON_MISALIGNED = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_waddr_i,
  output logic        lsu_busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic [4:0]  rf_waddr_lsu_o,
  output logic        resp_valid_o,
  output logic        load_err_o,
  output logic        store_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV} state_e;

  state_e      state_q;
  logic        we_q, sign_q, phase_q, split_q;
  logic [1:0]  type_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [4:0]  waddr_q;
  logic        req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] rf_wdata_q;
  logic [4:0]  rf_waddr_q;
  logic        rf_we_q, resp_q, load_err_q, store_err_q;
  logic        mis_in;

  function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] off);
    return typ[1] ? (off != 2'd0) : (typ[0] && (off == 2'd3));
  endfunction

  // Phase 1 only ever carries the bytes that spilled past the first word boundary.
  function automatic logic [3:0] be_calc(input logic [1:0] typ, input logic [1:0] off,
                                         input logic ph);
    logic [3:0] be;
    be = 4'b0001 << off;
    if (typ[1]) begin
      be = ph ? (4'b1111 >> (3'd4 - {1'b0, off})) : (4'b1111 << off);
    end else if (typ[0]) begin
      be = ph ? 4'b0001 : (4'b0011 << off);
    end
    return be;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    return 32'(({d, d} << {off, 3'b000}) >> 32);
  endfunction

  function automatic logic [31:0] load_result(input logic [31:0] lo, input logic [31:0] hi,
                                              input logic [1:0] typ, input logic sgn,
                                              input logic [1:0] off);
    logic [31:0] al;
    al = 32'({hi, lo} >> {off, 3'b000});
    if (typ[1]) return al;
    if (typ[0]) return {{16{sgn & al[15]}}, al[15:0]};
    return {{24{sgn & al[7]}}, al[7:0]};
  endfunction

  assign mis_in = is_misaligned(lsu_type_i, lsu_addr_i[1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      phase_q     <= 1'b0;
      split_q     <= 1'b0;
      type_q      <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      waddr_q     <= 5'h0;
      req_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
      rf_wdata_q  <= 32'h0;
      rf_waddr_q  <= 5'h0;
      rf_we_q     <= 1'b0;
      resp_q      <= 1'b0;
      load_err_q  <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      rf_we_q     <= 1'b0;
      resp_q      <= 1'b0;
      load_err_q  <= 1'b0;
      store_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            we_q    <= lsu_we_i;
            type_q  <= lsu_type_i;
            sign_q  <= lsu_sign_ext_i;
            addr_q  <= lsu_addr_i;
            wdata_q <= lsu_wdata_i;
            waddr_q <= lsu_waddr_i;
            if (mis_in && ERR_ON_MISALIGNED) begin
              resp_q      <= 1'b1;
              load_err_q  <= ~lsu_we_i;
              store_err_q <= lsu_we_i;
            end else begin
              state_q     <= REQ;
              phase_q     <= 1'b0;
              split_q     <= mis_in;
              req_q       <= 1'b1;
              bus_we_q    <= lsu_we_i;
              bus_addr_q  <= {lsu_addr_i[31:2], 2'b00};
              bus_be_q    <= be_calc(lsu_type_i, lsu_addr_i[1:0], 1'b0);
              bus_wdata_q <= rotl_bytes(lsu_wdata_i, lsu_addr_i[1:0]);
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WAIT_RV;
          end
        end
        WAIT_RV: begin
          if (data_rvalid_i) begin
            if (!phase_q && split_q && !data_err_i) begin
              rdata_q     <= data_rdata_i;
              phase_q     <= 1'b1;
              state_q     <= REQ;
              req_q       <= 1'b1;
              bus_addr_q  <= {addr_q[31:2], 2'b00} + 32'd4;
              bus_be_q    <= be_calc(type_q, addr_q[1:0], 1'b1);
              bus_wdata_q <= rotl_bytes(wdata_q, addr_q[1:0]);
            end else begin
              state_q <= IDLE;
              resp_q  <= 1'b1;
              if (data_err_i) begin
                load_err_q  <= ~we_q;
                store_err_q <= we_q;
              end else if (!we_q) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= waddr_q;
                rf_wdata_q <= split_q
                  ? load_result(rdata_q, data_rdata_i, type_q, sign_q, addr_q[1:0])
                  : load_result(data_rdata_i, 32'h0, type_q, sign_q, addr_q[1:0]);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_busy_o     = (state_q != IDLE);
  assign data_req_o     = req_q;
  assign data_addr_o    = bus_addr_q;
  assign data_we_o      = bus_we_q;
  assign data_be_o      = bus_be_q;
  assign data_wdata_o   = bus_wdata_q;
  assign rf_wdata_lsu_o = rf_wdata_q;
  assign rf_we_lsu_o    = rf_we_q;
  assign rf_waddr_lsu_o = rf_waddr_q;
  assign resp_valid_o   = resp_q;
  assign load_err_o     = load_err_q;
  assign store_err_o    = store_err_q;

endmodule

// File: tb/tb_lsu_data_if.sv
// Bench for lsu_data_if: directed and random operations against a byte-level model of the access.
module tb_lsu_data_if;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [4:0]  lsu_waddr_i;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic        lsu_busy_o, data_req_o, data_we_o, rf_we_lsu_o, resp_valid_o, load_err_o, store_err_o;
  logic [31:0] data_addr_o, data_wdata_o, rf_wdata_lsu_o;
  logic [3:0]  data_be_o;
  logic [4:0]  rf_waddr_lsu_o;

  logic        e_req, e_rvalid;
  logic        e_busy, e_dreq, e_dwe, e_rf_we, e_resp, e_lerr, e_serr;
  logic [31:0] e_daddr, e_dwdata, e_rf_wdata;
  logic [3:0]  e_be;
  logic [4:0]  e_rf_waddr;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_rf_wdata = 32'h0;
  logic [4:0]  exp_rf_waddr = 5'h0;

  lsu_data_if #(.ERR_ON_MISALIGNED(1'b0)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_waddr_i(lsu_waddr_i), .lsu_busy_o(lsu_busy_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .rf_wdata_lsu_o(rf_wdata_lsu_o), .rf_we_lsu_o(rf_we_lsu_o), .rf_waddr_lsu_o(rf_waddr_lsu_o),
    .resp_valid_o(resp_valid_o), .load_err_o(load_err_o), .store_err_o(store_err_o)
  );

  lsu_data_if #(.ERR_ON_MISALIGNED(1'b1)) u_dut_err (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(e_req), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_waddr_i(lsu_waddr_i), .lsu_busy_o(e_busy),
    .data_req_o(e_dreq), .data_gnt_i(1'b1), .data_rvalid_i(e_rvalid),
    .data_err_i(1'b0), .data_addr_o(e_daddr), .data_we_o(e_dwe),
    .data_be_o(e_be), .data_wdata_o(e_dwdata), .data_rdata_i(32'h0),
    .rf_wdata_lsu_o(e_rf_wdata), .rf_we_lsu_o(e_rf_we), .rf_waddr_lsu_o(e_rf_waddr),
    .resp_valid_o(e_resp), .load_err_o(e_lerr), .store_err_o(e_serr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_req"}, 32'(data_req_o), 32'd0);
    check_eq({tag, "_addr"}, data_addr_o, 32'd0);
    check_eq({tag, "_be"}, 32'(data_be_o), 32'd0);
    check_eq({tag, "_wdata"}, data_wdata_o, 32'd0);
    check_eq({tag, "_we"}, 32'(data_we_o), 32'd0);
    check_eq({tag, "_rf_wdata"}, rf_wdata_lsu_o, 32'd0);
    check_eq({tag, "_rf_waddr"}, 32'(rf_waddr_lsu_o), 32'd0);
    check_eq({tag, "_rf_we"}, 32'(rf_we_lsu_o), 32'd0);
    check_eq({tag, "_resp"}, 32'(resp_valid_o), 32'd0);
    check_eq({tag, "_errs"}, 32'({load_err_o, store_err_o}), 32'd0);
    check_eq({tag, "_busy"}, 32'(lsu_busy_o), 32'd0);
  endtask

  // One complete operation. err_ph selects the transaction answered with an error (-1: none),
  // gdel the grant delay in cycles (-1: random). Returns at the completion cycle.
  task automatic do_op(input logic we, input logic [1:0] typ, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] r0, input logic [31:0] r1, input int err_ph,
                       input int gdel);
    int n, o, ntx, last, lane, idx, waited, g;
    logic [3:0]  be_e [2];
    logic [31:0] wd_e, res, a0, rword;
    logic        err_hit;
    o = int'(addr[1:0]);
    n = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
    be_e[0] = 4'h0;
    be_e[1] = 4'h0;
    res = 32'h0;
    for (int k = 0; k < n; k++) begin
      lane = (o + k) % 4;
      idx  = (o + k) / 4;
      be_e[idx][lane] = 1'b1;
      rword = (idx == 0) ? r0 : r1;
      res[8*k +: 8] = rword[8*lane +: 8];
    end
    if (sg && n < 4 && res[8*n-1]) begin
      for (int k = n; k < 4; k++) res[8*k +: 8] = 8'hFF;
    end
    for (int l = 0; l < 4; l++) wd_e[8*l +: 8] = wd[8*((l - o + 4) % 4) +: 8];
    ntx = (o + n > 4) ? 2 : 1;
    a0 = {addr[31:2], 2'b00};
    err_hit = (err_ph >= 0) && (err_ph < ntx);
    last = (err_ph == 0) ? 0 : ntx - 1;

    check_eq("busy_before", 32'(lsu_busy_o), 32'd0);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sg;
    lsu_addr_i = addr; lsu_wdata_i = wd; lsu_waddr_i = rd;
    @(negedge clk_i);
    lsu_req_i = 1'b0; lsu_we_i = ~we; lsu_type_i = 2'($urandom); lsu_sign_ext_i = ~sg;
    lsu_addr_i = $urandom; lsu_wdata_i = $urandom; lsu_waddr_i = 5'($urandom);

    for (int t = 0; t <= last; t++) begin
      waited = 0;
      while (!data_req_o && waited < 8) begin
        @(negedge clk_i);
        waited++;
      end
      check_eq("req_seen", 32'(data_req_o), 32'd1);
      if (t == 0) check_eq("resp_pulse_end", 32'(resp_valid_o), 32'd0);
      check_eq("busy", 32'(lsu_busy_o), 32'd1);
      check_eq("bus_addr", data_addr_o, a0 + 32'(4 * t));
      check_eq("bus_be", 32'(data_be_o), 32'(be_e[t]));
      check_eq("bus_we", 32'(data_we_o), 32'(we));
      check_eq("bus_wdata", data_wdata_o, wd_e);
      g = (gdel < 0) ? int'($urandom_range(0, 2)) : gdel;
      repeat (g) begin
        data_rvalid_i = 1'($urandom_range(0, 1));
        data_err_i = 1'($urandom_range(0, 1));
        data_rdata_i = $urandom;
        lsu_req_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_err_i = 1'b0; lsu_req_i = 1'b0;
        check_eq("req_hold", 32'(data_req_o), 32'd1);
        check_eq("addr_hold", data_addr_o, a0 + 32'(4 * t));
      end
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      check_eq("req_drop", 32'(data_req_o), 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      data_rvalid_i = 1'b1;
      data_rdata_i = (t == 0) ? r0 : r1;
      data_err_i = (err_ph == t);
      @(negedge clk_i);
      data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = $urandom;
    end

    check_eq("resp", 32'(resp_valid_o), 32'd1);
    check_eq("rf_we", 32'(rf_we_lsu_o), 32'(!we && !err_hit));
    check_eq("load_err", 32'(load_err_o), 32'(!we && err_hit));
    check_eq("store_err", 32'(store_err_o), 32'(we && err_hit));
    check_eq("busy_done", 32'(lsu_busy_o), 32'd0);
    check_eq("no_more_req", 32'(data_req_o), 32'd0);
    if (!we && !err_hit) begin
      exp_rf_wdata = res;
      exp_rf_waddr = rd;
    end
    check_eq("rf_wdata", rf_wdata_lsu_o, exp_rf_wdata);
    check_eq("rf_waddr", 32'(rf_waddr_lsu_o), 32'(exp_rf_waddr));
  endtask

  task automatic err_dut_op(input logic we, input logic [1:0] typ, input logic [31:0] addr,
                            input logic exp_err);
    lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = 1'b1; lsu_addr_i = addr;
    lsu_wdata_i = 32'h1234_5678; lsu_waddr_i = 5'd11; e_req = 1'b1;
    @(negedge clk_i);
    e_req = 1'b0;
    check_eq("err_resp", 32'(e_resp), 32'(exp_err));
    check_eq("err_lerr", 32'(e_lerr), 32'(exp_err && !we));
    check_eq("err_serr", 32'(e_serr), 32'(exp_err && we));
    check_eq("err_req", 32'(e_dreq), 32'(!exp_err));
    check_eq("err_busy", 32'(e_busy), 32'(!exp_err));
    @(negedge clk_i);
    check_eq("err_pulse_end", 32'({e_resp, e_lerr, e_serr}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'd0; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0; lsu_waddr_i = 5'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
    e_req = 1'b0; e_rvalid = 1'b0;
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 32'h0, -1, 2);
    do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 32'h80112233, 32'h0, -1, -1);
    check_eq("lb_signed", rf_wdata_lsu_o, 32'hFFFFFF80);
    do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80112233, 32'h0, -1, -1);
    check_eq("lbu", rf_wdata_lsu_o, 32'h00000080);
    do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd9, 32'h11223344, 32'h55667788, -1, -1);
    check_eq("lw_split", rf_wdata_lsu_o, 32'h77881122);
    do_op(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000ABCD, 5'd3, 32'h0, 32'h0, -1, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 5'd4, 32'hAAAA5555, 32'h0, 0, -1);
    do_op(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd6, 32'h8000_0000, 32'h0000_00F1, -1, 1);
    do_op(1'b0, 2'd3, 1'b0, 32'h0000_0201, 32'h0, 5'd8, 32'h0102_0304, 32'h0506_0708, 1, -1);

    // Reset in the middle of a load, then a late rvalid that must be ignored.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'd2; lsu_addr_i = 32'h200; lsu_waddr_i = 5'd12;
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1 check_outputs_zero("mid_reset");
    exp_rf_wdata = 32'h0;
    exp_rf_waddr = 5'h0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_outputs_zero("after_reset");
    do_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd13, 32'h0BAD_F00D, 32'h0, -1, -1);
    @(negedge clk_i);

    err_dut_op(1'b0, 2'd2, 32'h102, 1'b1);
    err_dut_op(1'b1, 2'd1, 32'h103, 1'b1);
    err_dut_op(1'b0, 2'd0, 32'h103, 1'b0);
    check_eq("err_dut_be", 32'(e_be), 32'h8);
    e_rvalid = 1'b1;
    @(negedge clk_i);
    e_rvalid = 1'b0;
    check_eq("err_dut_rf_we", 32'(e_rf_we), 32'd1);
    check_eq("err_dut_rf_waddr", 32'(e_rf_waddr), 32'd11);

    for (int i = 0; i < 150; i++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, 5'($urandom), $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1, -1);
      if ($urandom_range(0, 3) == 0) begin
        data_rvalid_i = 1'b1; data_err_i = 1'($urandom_range(0, 1)); data_rdata_i = $urandom;
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
        check_eq("idle_rvalid_resp", 32'(resp_valid_o), 32'd0);
        check_eq("idle_rvalid_busy", 32'(lsu_busy_o), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
